request_unit: RTL

//  Sequences single-cycle datapath memory traffic downstream of the control unit.

---
 rtl/cpu_types_pkg.sv | 5 +
 rtl/sat_counter.sv | 11 +
 rtl/request_unit.sv | 67 ++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types for the datapath control blocks.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FETCH, MEM, HALTED} req_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(parameter int W = 32) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge CLK or posedge RST)
      if (RST) count <= '0;
      else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/request_unit.sv
// request_unit: sequences imem/dmem requests, PC advance, sticky halt and perf counters.
module request_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_in,
   input  logic             dWEN_in,
   input  logic             halt_in,
   output logic             imemREN,
   output logic             dmemREN,
   output logic             dmemWEN,
   output logic             pcEN,
   output logic             halt,
   output logic [CNT_W-1:0] instr_count,
   output logic [CNT_W-1:0] stall_count
);
   req_state_t state, next_state;
   logic instr_inc, stall_inc, mem_req;
   assign mem_req = dREN_in | dWEN_in;
   assign halt = state == HALTED;
   // pcEN is gated by RST so a held ihit cannot advance the PC while in reset
   always_comb begin
      next_state = state;
      imemREN = 1'b0;
      pcEN = 1'b0;
      instr_inc = 1'b0;
      stall_inc = 1'b0;
      case (state)
         FETCH: begin
            imemREN = 1'b1;
            stall_inc = ~ihit;
            instr_inc = ihit & (halt_in | ~mem_req);
            pcEN = ihit & ~halt_in & ~mem_req & ~RST;
            next_state = !ihit ? FETCH : halt_in ? HALTED : mem_req ? MEM : FETCH;
         end
         MEM: begin
            pcEN = dhit & ~RST;
            instr_inc = dhit;
            stall_inc = ~dhit;
            next_state = dhit ? FETCH : MEM;
         end
         default: ;
      endcase
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= FETCH;
         dmemREN <= 1'b0;
         dmemWEN <= 1'b0;
      end else begin
         state <= next_state;
         if (state == FETCH && ihit && !halt_in && mem_req) begin
            dmemWEN <= dWEN_in;
            dmemREN <= dREN_in & ~dWEN_in;
         end else if (state == MEM && dhit) begin
            dmemWEN <= 1'b0;
            dmemREN <= 1'b0;
         end
      end
   sat_counter #(.W(CNT_W)) u_instr (.CLK(CLK), .RST(RST), .inc(instr_inc), .count(instr_count));
   sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .RST(RST), .inc(stall_inc), .count(stall_count));
endmodule
